// File: rtl/mini_proc_pkg.sv
// mini_proc_pkg: shared definitions for the mini_proc processor slice.
//   - opcode encodings (OP_NOP .. OP_PEEK)
//   - instruction field bit positions for the fixed 32-bit format
//   - op_writes(): whether an opcode commits its result to the data store
package mini_proc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_MOV  = 4'hA;
    localparam logic [3:0] OP_NEG  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_ROL  = 4'hD;
    localparam logic [3:0] OP_ROR  = 4'hE;
    localparam logic [3:0] OP_PEEK = 4'hF;

    // Instruction field positions
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned IMM_BIT = 27;
    localparam int unsigned RSV_MSB = 26;
    localparam int unsigned RSV_LSB = 24;
    localparam int unsigned DST_MSB = 23;
    localparam int unsigned DST_LSB = 16;
    localparam int unsigned A_MSB   = 15;
    localparam int unsigned A_LSB   = 8;
    localparam int unsigned B_MSB   = 7;
    localparam int unsigned B_LSB   = 0;

    // NOP and PEEK only update o; everything else writes store[dst].
    function automatic logic op_writes(input logic [3:0] opc);
        return (opc != OP_NOP) && (opc != OP_PEEK);
    endfunction

endpackage

// File: rtl/mini_proc_if.sv
// mini_proc_if: instruction/result bus of mini_proc.
//   x : instruction word, driven by the controller (master)
//   o : registered result, driven by the processor (slave)
interface mini_proc_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] x;
    logic [7:0]       o;

    modport master (output x, input o);
    modport slave  (input x, output o);
endinterface

// File: rtl/mini_proc_alu.sv
// mini_proc_alu: purely combinational 8-bit ALU of mini_proc.
//   opc : 4-bit opcode
//   a   : operand A (store[a_adr])
//   b   : operand B (immediate or store[b_fld])
//   o   : current result register, returned unchanged for NOP
//   r   : 8-bit result, all arithmetic modulo 256
module mini_proc_alu
    import mini_proc_pkg::*;
(
    input  logic [3:0] opc,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] o,
    output logic [7:0] r
);

    logic [2:0] sh;

    always_comb begin
        sh = b[2:0];
        r  = '0;
        unique case (opc)
            OP_NOP:  r = o;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_SHL:  r = a << sh;
            OP_SHR:  r = a >> sh;
            OP_LDI:  r = b;
            OP_MOV:  r = a;
            OP_NEG:  r = 8'd0 - a;
            OP_MUL:  r = a * b;
            // Rotates via a doubled copy so a shift of 0 needs no special case.
            OP_ROL:  r = 8'(({a, a} << sh) >> 8);
            OP_ROR:  r = 8'({a, a} >> sh);
            OP_PEEK: r = a;
            default: r = o;
        endcase
    end

endmodule

// File: rtl/mini_proc.sv
// mini_proc: single-cycle 8-bit register-memory processor slice.
//   clk   : system clock, rising edge executes one instruction
//   rst_n : asynchronous active-low reset, clears o and the whole store
//   bus   : mini_proc_if slave; bus.x instruction in, bus.o registered result
// Holds the 256 x 8 data store, operand selection and the o register.
module mini_proc
    import mini_proc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256
)(
    input logic        clk,
    input logic        rst_n,
    mini_proc_if.slave bus
);

    logic [7:0] mem [DEPTH];

    logic [3:0] opc;
    logic       imm_sel;
    logic [7:0] dst;
    logic [7:0] a_adr;
    logic [7:0] b_fld;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       unused_rsv;

    assign opc        = bus.x[OPC_MSB:OPC_LSB];
    assign imm_sel    = bus.x[IMM_BIT];
    assign dst        = bus.x[DST_MSB:DST_LSB];
    assign a_adr      = bus.x[A_MSB:A_LSB];
    assign b_fld      = bus.x[B_MSB:B_LSB];
    assign unused_rsv = ^bus.x[RSV_MSB:RSV_LSB];

    // Reads see pre-edge contents, so dst==source hazards use the old value.
    assign a = mem[a_adr];
    assign b = imm_sel ? b_fld : mem[b_fld];

    mini_proc_alu u_alu (
        .opc (opc),
        .a   (a),
        .b   (b),
        .o   (bus.o),
        .r   (r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (op_writes(opc)) begin
            mem[dst] <= r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o <= '0;
        end else begin
            bus.o <= r;
        end
    end

endmodule

// File: tb/tb_mini_proc.sv
// tb_mini_proc: directed self-checking bench for mini_proc.
module tb_mini_proc;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mini_proc_if #(.WIDTH(32)) bus ();

    mini_proc #(.WIDTH(32), .DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an instruction at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [31:0] ins);
        @(negedge clk);
        bus.x = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.x = 32'hC3C32323;
        #12;
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: o=%h expected 00", bus.o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL reset_mul_zero: o=%h expected 00", bus.o);
        end
        step(32'hF000C300);
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL reset_store_c3: o=%h expected 00", bus.o);
        end
    endtask

    task automatic test_or_imm();
        step(32'h499602D2);
        checks++;
        if (bus.o !== 8'hD2) begin
            errors++;
            $display("FAIL or_imm: o=%h expected d2", bus.o);
        end
        step(32'hF0009600);
        checks++;
        if (bus.o !== 8'hD2) begin
            errors++;
            $display("FAIL or_imm_store: o=%h expected d2", bus.o);
        end
    endtask

    task automatic test_chain();
        step(32'h9805002A);
        checks++;
        if (bus.o !== 8'h2A) begin
            errors++;
            $display("FAIL chain_ldi: o=%h expected 2a", bus.o);
        end
        step(32'h18060510);
        checks++;
        if (bus.o !== 8'h3A) begin
            errors++;
            $display("FAIL chain_add: o=%h expected 3a", bus.o);
        end
        step(32'h2807063B);
        checks++;
        if (bus.o !== 8'hFF) begin
            errors++;
            $display("FAIL chain_sub_wrap: o=%h expected ff", bus.o);
        end
        step(32'hF0000600);
        checks++;
        if (bus.o !== 8'h3A) begin
            errors++;
            $display("FAIL chain_store_06: o=%h expected 3a", bus.o);
        end
    endtask

    task automatic test_mul();
        step(32'h98730005);
        step(32'h98610033);
        step(32'hC1E57361);
        checks++;
        if (bus.o !== 8'hFF) begin
            errors++;
            $display("FAIL mul_store: o=%h expected ff", bus.o);
        end
        step(32'hF000E500);
        checks++;
        if (bus.o !== 8'hFF) begin
            errors++;
            $display("FAIL mul_store_e5: o=%h expected ff", bus.o);
        end
        step(32'h3D5532C1);
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL and_imm_zero: o=%h expected 00", bus.o);
        end
    endtask

    // dst aliasing a source reads the old value; the next instruction sees the new one.
    task automatic test_back_to_back();
        step(32'h98400010);
        step(32'h18404001);
        checks++;
        if (bus.o !== 8'h11) begin
            errors++;
            $display("FAIL hazard_dst_a_1: o=%h expected 11", bus.o);
        end
        step(32'h18404001);
        checks++;
        if (bus.o !== 8'h12) begin
            errors++;
            $display("FAIL hazard_dst_a_2: o=%h expected 12", bus.o);
        end
        step(32'h10414041);
        checks++;
        if (bus.o !== 8'h12) begin
            errors++;
            $display("FAIL hazard_dst_b_1: o=%h expected 12", bus.o);
        end
        step(32'h10414041);
        checks++;
        if (bus.o !== 8'h24) begin
            errors++;
            $display("FAIL hazard_dst_b_2: o=%h expected 24", bus.o);
        end
    endtask

    task automatic test_shift_unary();
        logic [31:0] ins [8];
        logic [7:0]  exp [8];
        ins = '{32'h98100081, 32'hD8201001, 32'h88211009, 32'hE8221003,
                32'h78231004, 32'h68241000, 32'hB8251000, 32'h5826103C};
        exp = '{8'h81, 8'h03, 8'h40, 8'h30, 8'h10, 8'h7E, 8'h7F, 8'hBD};
        for (int i = 0; i < 8; i++) begin
            step(ins[i]);
            checks++;
            if (bus.o !== exp[i]) begin
                errors++;
                $display("FAIL shift_unary[%0d] x=%h: o=%h expected %h", i, ins[i], bus.o, exp[i]);
            end
        end
        step(32'hA8271000);
        checks++;
        if (bus.o !== 8'h81) begin
            errors++;
            $display("FAIL mov: o=%h expected 81", bus.o);
        end
    endtask

    task automatic test_nonwrite();
        step(32'h98FF005A);
        step(32'hF8FF1000);
        checks++;
        if (bus.o !== 8'h81) begin
            errors++;
            $display("FAIL peek: o=%h expected 81", bus.o);
        end
        step(32'hF000FF00);
        checks++;
        if (bus.o !== 8'h5A) begin
            errors++;
            $display("FAIL peek_no_write: o=%h expected 5a", bus.o);
        end
        step(32'hF0001000);
        step(32'h0FAA1055);
        checks++;
        if (bus.o !== 8'h81) begin
            errors++;
            $display("FAIL nop_hold_1: o=%h expected 81", bus.o);
        end
        step(32'h00000000);
        checks++;
        if (bus.o !== 8'h81) begin
            errors++;
            $display("FAIL nop_hold_2: o=%h expected 81", bus.o);
        end
        step(32'hF000AA00);
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL nop_no_write: o=%h expected 00", bus.o);
        end
        step(32'hF0001000);
    endtask

    task automatic test_async_reset();
        // Pulse between edges: o must clear without any clock edge.
        @(negedge clk);
        bus.x = 32'h00000000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_o: o=%h expected 00", bus.o);
        end
        rst_n = 1'b1;
        step(32'hF0001000);
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_store_10: o=%h expected 00", bus.o);
        end
        step(32'hF000FF00);
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_store_ff: o=%h expected 00", bus.o);
        end
        // Reset held across an edge aborts the pending write.
        @(negedge clk);
        bus.x = 32'h98300077;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL abort_write_o: o=%h expected 00", bus.o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.x = 32'hF0003000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.o !== 8'h00) begin
            errors++;
            $display("FAIL abort_write_store_30: o=%h expected 00", bus.o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.x  = '0;
        test_reset();
        test_or_imm();
        test_chain();
        test_mul();
        test_back_to_back();
        test_shift_unary();
        test_nonwrite();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mini_proc.md
Name: mini_proc

Overview:
- Single-cycle 8-bit register-memory processor slice. Each rising clock edge executes one 32-bit instruction presented on `x`.
- Contains a 256 x 8 data store. The result of each instruction is written back to the store and presented, registered, on `o`.
- Used as a standalone compute block driven by a controller or bench that supplies one instruction per cycle.

Parameters:
- WIDTH, 32, instruction word width; the field layout below is fixed for 32.
- DEPTH, 256, number of 8-bit storage locations; addresses are 8 bits.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- x  input  WIDTH  instruction word, sampled every rising edge
- o  output  8  registered result of the most recently executed instruction

Behaviour:
- Instruction fields:
  - opc = x[31:28]
  - imm_sel = x[27]
  - x[26:24] reserved, ignored
  - dst = x[23:16]
  - a_adr = x[15:8]
  - b_fld = x[7:0]
- Operands:
  - A = store[a_adr].
  - B = b_fld when imm_sel = 1, else store[b_fld].
  - Reads are combinational from current store contents, i.e. pre-edge values.
- Opcodes; R is the 8-bit result, and all arithmetic wraps modulo 256:
  - 0 NOP: R = o, no write.
  - 1 ADD: A+B.
  - 2 SUB: A-B.
  - 3 AND: A&B.
  - 4 OR: A|B.
  - 5 XOR: A^B.
  - 6 NOT: ~A.
  - 7 SHL: A << B[2:0].
  - 8 SHR: A >> B[2:0], logical.
  - 9 LDI: R = B.
  - A MOV: R = A.
  - B NEG: 0-A.
  - C MUL: low 8 bits of A*B.
  - D ROL: A rotated left by B[2:0].
  - E ROR: A rotated right by B[2:0].
  - F PEEK: R = A, no write.
- Every opcode except 0 and F writes store[dst] <= R at the rising edge.
- Output: o <= R at the same edge. Latency is one clock, with no handshake; every edge consumes an instruction.
- Hazards:
  - dst equal to a_adr or b_fld: operands use the old value; the new value is visible from the next instruction.
  - Back-to-back dependent instructions see the prior write, with no bubbles.
- Reset (rst_n low, asynchronous): o = 0x00 and all 256 store locations = 0x00, immediately and while held.
- Release: the first instruction executes on the first rising edge with rst_n high.
- Reset asserted mid-operation aborts the current write and clears all state.

Decomposition:
- Package mini_proc_pkg holds:
  - opcode localparams OP_NOP..OP_PEEK
  - field bit-position constants
  - a function for whether an opcode writes
- One sub-module, mini_proc_alu: purely combinational, inputs (opc, A, B, o), output R.
- The top module holds the store array, operand muxing and the o register.

Test Plan:
1. Reset then zero memory: assert rst_n=0 with x=0xC3C32323, release, one clock -> o=0x00 (MUL 0*0), store[0xC3]=0x00.
2. OR immediate: after reset, x=0x499602D2 -> o=0xD2 next edge, store[0x96]=0xD2.
3. Chained dependency:
   - x=0x98050000|0x2A (LDI imm 0x2A to 0x05) -> o=0x2A.
   - Then x=0x18060510 -> o=0x3A, store[0x06]=0x3A.
   - Then x=0x2807063B -> o=0xFF (wrap).
4. Store-operand MUL: after store[0x73]=0x05 and store[0x61]=0x33 loaded by LDI, x=0xC1E57361 -> o=0xFF, store[0xE5]=0xFF.
   - Then x=0x3D5532C1 (AND imm, store[0x32]=0) -> o=0x00.
5. Shifts/rotates: store[0x10]=0x81.
   - ROL imm 1 (x=0xD8201001) -> o=0x03.
   - SHR imm 9, which uses B[2:0]=1 (x=0x88211009) -> o=0x40.
6. Non-writing ops and async reset:
   - PEEK x=0xF8FF1000 -> o=0x81 and store[0xFF] unchanged.
   - NOP -> o holds.
   - Pulse rst_n low between edges -> o=0x00 immediately, store[0x10]=0x00 after release.
